// File: rtl/addsub_pkg.sv
// Shared encodings for the serial adder/subtractor: operation codes, FSM states
// and the operation-to-initial-carry mapping.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ADDC = 2'b01,
        OP_SUB  = 2'b10,
        OP_SUBC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Subtraction is A + ~B + 1, so the borrow-in enters as an inverted carry.
    function automatic logic init_carry(input op_e op, input logic cin);
        logic c;
        c = 1'b0;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_ADDC: c = cin;
            OP_SUB:  c = 1'b1;
            OP_SUBC: c = ~cin;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit adder slice; also exposes the carry into its top bit
// so the parent can form two's-complement overflow.
module addsub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             c_o,
    output logic             c_top_o
);

    logic [DIGIT:0] full;

    assign full  = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT{1'b0}}, c_i};
    assign sum_o = full[DIGIT-1:0];
    assign c_o   = full[DIGIT];
    // The top sum bit is a ^ b ^ carry_in, so XOR recovers the carry into it.
    assign c_top_o = a_i[DIGIT-1] ^ b_i[DIGIT-1] ^ sum_o[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract unit: WIDTH/DIGIT RUN cycles, LSB slice first, then a
// one-cycle DONE. Define ADDSUB_SERIAL_OVF_EN to add the registered ovf output.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       s,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
`ifdef ADDSUB_SERIAL_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   acc_shift;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;

    logic [DIGIT-1:0]   slice_sum;
    logic               slice_cout;
    logic               slice_c_top;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_i     (a_q[DIGIT-1:0]),
        .b_i     (b_q[DIGIT-1:0]),
        .c_i     (carry_q),
        .sum_o   (slice_sum),
        .c_o     (slice_cout),
        .c_top_o (slice_c_top)
    );

`ifdef ADDSUB_SERIAL_OVF_EN
    logic ovf_q, ovf_d;
`else
    logic unused_c_top;
    assign unused_c_top = slice_c_top;
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
`ifdef ADDSUB_SERIAL_OVF_EN
        ovf_d    = ovf_q;
`endif
        // New slice enters at the top; after NSLICE shifts the LSB slice sits at bit 0.
        acc_shift = acc_q >> DIGIT;
        acc_shift[WIDTH-1 -: DIGIT] = slice_sum;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = s[1] ? ~b : b;
                    carry_d = init_carry(op_e'(s), cin);
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_shift;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    result_d = acc_shift;
                    cout_d   = slice_cout;
                    zero_d   = (acc_shift == '0);
`ifdef ADDSUB_SERIAL_OVF_EN
                    ovf_d    = slice_c_top ^ slice_cout;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand/accumulator datapath has no reset; it is always loaded on accept before use.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        acc_q   <= acc_d;
        carry_q <= carry_d;
        cnt_q   <= cnt_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ADDSUB_SERIAL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
`ifdef ADDSUB_SERIAL_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
`ifdef ADDSUB_SERIAL_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial (WIDTH=8, DIGIT=2): arithmetic/latency model compared every
// cycle, plus directed vectors with hand-computed results.
module tb_addsub_serial;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int NS = W / D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   s = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
`ifdef ADDSUB_SERIAL_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    addsub_serial #(.WIDTH(W), .DIGIT(D)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .s      (s),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero)
`ifdef ADDSUB_SERIAL_OVF_EN
       ,.ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: {ovf, cout, result} from plain two's-complement maths.
    function automatic logic [W+1:0] model_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                                              input logic [1:0] ts, input logic tc);
        logic [W-1:0] eb;
        logic [W:0]   full;
        logic         c0;
        logic         v;
        eb = ts[1] ? ~tbv : tbv;
        case (ts)
            2'b00:   c0 = 1'b0;
            2'b01:   c0 = tc;
            2'b10:   c0 = 1'b1;
            default: c0 = ~tc;
        endcase
        full = {1'b0, ta} + {1'b0, eb} + {{W{1'b0}}, c0};
        v = (ta[W-1] == eb[W-1]) && (full[W-1] != ta[W-1]);
        return {v, full[W], full[W-1:0]};
    endfunction

    // Protocol model: an accepted op runs NS cycles, then results appear with done.
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_res = '0;
    logic         m_cout = 1'b0;
    logic         m_zero = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W+1:0] pend = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
            m_cout = 1'b0;
            m_zero = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_done) begin
                {m_ovf, m_cout, m_res} = pend;
                m_zero = (pend[W-1:0] == '0);
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                pend   = model_op(a, b, s, cin);
                m_left = NS;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp busy", busy, (m_left > 0));
            check("cmp done", done, m_done);
            check("cmp result", result, m_res);
            check("cmp cout", cout, m_cout);
            check("cmp zero", zero, m_zero);
`ifdef ADDSUB_SERIAL_OVF_EN
            check("cmp ovf", ovf, m_ovf);
`endif
        end
    end

    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic [1:0] ts, input logic tc);
        a = ta; b = tbv; s = ts; cin = tc; start = 1'b1;
    endtask

    // Counts sampling points after the accept edge until done; poke_k injects a start mid-RUN.
    task automatic wait_done(input string name, input int poke_k);
        int   lat;
        logic busy1;
        lat = 0;
        busy1 = 1'bx;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = busy;
            if (k == poke_k) begin
                a = 8'hAA; b = 8'h11; s = 2'b00; cin = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) lat = k;
        end
        check({name, " busy after accept"}, busy1, 1);
        check({name, " latency"}, lat, NS + 1);
    endtask

    task automatic run_vec(input string name, input bit chain,
                           input logic [W-1:0] ta, input logic [W-1:0] tbv,
                           input logic [1:0] ts, input logic tc,
                           input logic [W-1:0] er, input logic ec, input logic ez,
                           input logic eo, input int poke_k);
        if (!chain) @(negedge clk);
        launch(ta, tbv, ts, tc);
        wait_done(name, poke_k);
        check({name, " result"}, result, er);
        check({name, " cout"}, cout, ec);
        check({name, " zero"}, zero, ez);
`ifdef ADDSUB_SERIAL_OVF_EN
        check({name, " ovf"}, ovf, eo);
`endif
        check({name, " model"}, {m_ovf, m_cout, m_zero, m_res}, {eo, ec, ez, er});
    endtask

    initial begin
        int ndone;

        // Reset state
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset flags", {cout, zero}, 0);
        rst_n = 1'b1;

        run_vec("add 7F+01", 1'b0, 8'h7F, 8'h01, 2'b00, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 0);
        run_vec("sub 05-05", 1'b0, 8'h05, 8'h05, 2'b10, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0);
        run_vec("addc FF+00+1", 1'b0, 8'hFF, 8'h00, 2'b01, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 0);
        run_vec("subc 10-01-b", 1'b0, 8'h10, 8'h01, 2'b11, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0, 2);
        run_vec("sub 80-01", 1'b0, 8'h80, 8'h01, 2'b10, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1, 0);
        run_vec("sub 00-01", 1'b0, 8'h00, 8'h01, 2'b10, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
        run_vec("addc 3C+0F+0", 1'b0, 8'h3C, 8'h0F, 2'b01, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0, 0);

        // Back-to-back: second start issued in the DONE cycle
        run_vec("b2b first", 1'b0, 8'h01, 8'h02, 2'b00, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 0);
        run_vec("b2b second", 1'b1, 8'h33, 8'h11, 2'b10, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 0);

        // Reset during the 3rd RUN cycle
        @(negedge clk);
        launch(8'h12, 8'h34, 2'b00, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun rst busy", busy, 0);
        check("midrun rst done", done, 0);
        check("midrun rst result", result, 0);
        check("midrun rst cout", cout, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("midrun rst no done", ndone, 0);

        // Start sampled together with reset is discarded
        rst_n = 1'b0;
        launch(8'h55, 8'h01, 2'b00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("rst+start busy", busy, 0);

        run_vec("post-rst C0+40", 1'b0, 8'hC0, 8'h40, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0);
        @(negedge clk);
        check("return idle busy", busy, 0);
        check("return idle done", done, 0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (≥2).
REQ-002 The block SHALL have parameter DIGIT, default 2, bits processed per cycle; WIDTH mod DIGIT SHALL equal 0.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, request to begin an operation.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, operands.
REQ-008 The block SHALL have port s, input, 2, operation: 00 add, 01 add-with-carry, 10 subtract, 11 subtract-with-borrow.
REQ-009 The block SHALL have port cin, input, 1, carry-in for s=01/11.
REQ-010 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have port result, output, WIDTH, registered sum/difference.
REQ-013 The block SHALL have ports cout and zero, output, 1 each, registered carry-out and result-equals-zero flags.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; reset state IDLE.
REQ-015 start SHALL be accepted only in IDLE or DONE; on acceptance a, b, s and cin SHALL be captured and the FSM SHALL enter RUN.
REQ-016 start in RUN SHALL be ignored, with no effect on captured operands or progress.
REQ-017 The effective B SHALL be ~b for s=1x and b for s=0x; the initial carry SHALL be 0, cin, 1 and ~cin for s=00, 01, 10 and 11 respectively.
REQ-018 RUN SHALL last exactly WIDTH/DIGIT cycles, each adding one DIGIT-bit slice LSB-first and propagating carry through a registered carry bit.
REQ-019 After the last RUN cycle the FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE unless a new start is accepted.
REQ-020 result, cout and zero SHALL update only on the RUN→DONE transition and SHALL hold until the next such transition.
REQ-021 cout SHALL be the raw carry out of the MSB slice, with no borrow inversion, so subtraction without borrow gives cout=1.
REQ-022 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-023 Latency SHALL be WIDTH/DIGIT+1 cycles from the start-accept edge to done=1; back-to-back start in DONE SHALL give one result per WIDTH/DIGIT+1 cycles.

Reset
REQ-024 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE and busy, done, result, cout and zero (and ovf if present) SHALL be cleared to 0, including when reset occurs mid-RUN; a start sampled in the same cycle SHALL be discarded.

Configuration
REQ-025 With macro ADDSUB_SERIAL_OVF_EN defined, the block SHALL have an output ovf (1 bit) giving registered two's-complement overflow (carry into MSB XOR carry out of MSB), updated under the same rule as cout.
REQ-026 Without ADDSUB_SERIAL_OVF_EN, ovf SHALL not exist and no overflow logic SHALL be built.

Structure
REQ-027 Package addsub_pkg SHALL hold the op encoding enum (OP_ADD, OP_ADDC, OP_SUB, OP_SUBC) and the FSM state enum.
REQ-028 Sub-module addsub_digit SHALL be a combinational DIGIT-bit adder (inputs: slice a, slice b, carry-in; outputs: sum slice, carry-out, carry into top bit), instantiated once.
REQ-029 The shift/slice counter SHALL be $clog2(WIDTH/DIGIT) bits wide, minimum 1.

Verification (WIDTH=8, DIGIT=2)
REQ-030 The bench SHALL drive a=0x7F, b=0x01, s=00 and expect done 5 cycles after accept, result=0x80, cout=0, zero=0, ovf=1.
REQ-031 The bench SHALL drive a=0x05, b=0x05, s=10 and expect result=0x00, cout=1, zero=1, ovf=0.
REQ-032 The bench SHALL drive a=0xFF, b=0x00, s=01, cin=1 and expect result=0x00, cout=1, zero=1.
REQ-033 The bench SHALL drive a=0x10, b=0x01, s=11, cin=1 and expect result=0x0E, cout=1; a second start 2 cycles after accept, with different operands, SHALL be ignored and leave the result unchanged.
REQ-034 The bench SHALL assert rst_n=0 in the 3rd RUN cycle and expect the next cycle to show busy=0, done=0, result=0x00; no done pulse SHALL follow.
REQ-035 The bench SHALL assert start in the DONE cycle and expect immediate acceptance, busy=1 next cycle, and a second done exactly 5 cycles later.
